// File: rtl/lieat_ifu_ibuf_if.sv
`default_nettype none
// ============================================================================
//  Module      : lieat_ifu_ibuf_if
//  Description : Instruction handshake bundle (valid/ready plus pc, inst and
//                predict flag) shared by the IFU fetch side and the IDU side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lieat_ifu_ibuf_if #(
    parameter int XLEN = 32
);
    logic            valid;
    logic            ready;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            prdt_taken;

    // Producer of instructions drives valid and payload, consumer drives ready.
    modport master (output valid, output pc, output inst, output prdt_taken, input ready);
    modport slave  (input valid, input pc, input inst, input prdt_taken, output ready);
endinterface
`default_nettype wire

// File: rtl/lieat_ifu_ibuf.sv
`default_nettype none
// ============================================================================
//  Module      : lieat_ifu_ibuf
//  Description : DEPTH-entry in-order instruction buffer between the fetch
//                response and the IDU. Flush drops all buffered entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module lieat_ifu_ibuf #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wire                  clock,
    input  wire                  reset,
    lieat_ifu_ibuf_if.slave      if_i,
    lieat_ifu_ibuf_if.master     id_i,
    input  wire                  flush_req,
    output logic [PTR_W:0]       ibuf_count,
    output logic                 ibuf_empty
);

    localparam logic [PTR_W:0] c_PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic [XLEN-1:0]  r_pc_mem   [DEPTH];
    logic [XLEN-1:0]  r_inst_mem [DEPTH];
    logic [DEPTH-1:0] r_prdt_mem;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_wr_idx;
    logic [PTR_W-1:0] w_rd_idx;

    // Occupancy decode and handshake qualification; flush gates both sides.
    always_comb begin
        w_wr_idx = r_wr_ptr[PTR_W-1:0];
        w_rd_idx = r_rd_ptr[PTR_W-1:0];
        w_empty  = (r_wr_ptr == r_rd_ptr);
        w_full   = (w_wr_idx == w_rd_idx) && (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);
        w_push   = if_i.valid && !w_full && !flush_req;
        w_pop    = !w_empty && !flush_req && id_i.ready;
    end

    // The full case never accepts, even alongside a pop, to keep ready
    // independent of the IDU's ready.
    assign if_i.ready      = !w_full && !flush_req;
    assign id_i.valid      = !w_empty && !flush_req;
    assign id_i.pc         = r_pc_mem[w_rd_idx];
    assign id_i.inst       = r_inst_mem[w_rd_idx];
    assign id_i.prdt_taken = r_prdt_mem[w_rd_idx];
    assign ibuf_count      = r_wr_ptr - r_rd_ptr;
    assign ibuf_empty      = w_empty;

    // Pointer update: a flush snaps the read pointer onto the write pointer,
    // which cannot move in the same cycle because push is gated by flush.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (flush_req) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Entry storage; flushed entries stay in place but are never presented.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]   <= '0;
                r_inst_mem[i] <= '0;
            end
            r_prdt_mem <= '0;
        end else if (w_push) begin
            r_pc_mem[w_wr_idx]   <= if_i.pc;
            r_inst_mem[w_wr_idx] <= if_i.inst;
            r_prdt_mem[w_wr_idx] <= if_i.prdt_taken;
        end
    end

endmodule
`default_nettype wire
